microchip_sync_fifo: RTL
========================

MICROCHIP_SYNC_FIFO -- requirements
Module: microchip_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data word width in bits (1..36).
REQ-002 SHALL have parameter DEPTH, default 64, number of storage entries (power of two, 4..1024).
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-4, occupancy at or above which AFULL asserts.
REQ-004 SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port ALn, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port CLR, input, 1, synchronous clear, active-high.
REQ-007 SHALL have port W_EN, input, 1, write request.
REQ-008 SHALL have port W_DATA, input, WIDTH, write data.
REQ-009 SHALL have port R_EN, input, 1, read request.
REQ-010 SHALL have port R_DATA, output, WIDTH, registered read data.
REQ-011 SHALL have port R_VALID, output, 1, R_DATA holds a newly read word this cycle.
REQ-012 SHALL have ports FULL, EMPTY and AFULL, output, 1 each, status flags.
REQ-013 SHALL have port COUNT, output, log2(DEPTH)+1, current occupancy.
REQ-014 SHALL have ports OVF and UNF, output, 1 each, sticky overflow/underflow error flags.

Function
REQ-015 SHALL accept a write when W_EN=1 and either FULL=0, or R_EN=1 with EMPTY=0 in the same cycle.
REQ-016 SHALL accept a read when R_EN=1 and EMPTY=0; a write in the same cycle SHALL NOT make a read of an empty FIFO legal.
REQ-017 SHALL store accepted write data at the write pointer and increment it modulo DEPTH.
REQ-018 SHALL increment the read pointer modulo DEPTH on an accepted read.
REQ-019 SHALL present the read word on R_DATA and pulse R_VALID exactly one cycle after read acceptance (latency 1).
REQ-020 SHALL hold R_DATA unchanged when no read is accepted.
REQ-021 SHALL update COUNT as follows: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-022 SHALL derive FULL (COUNT==DEPTH), EMPTY (COUNT==0) and AFULL (COUNT>=AFULL_LEVEL) from registered state, valid in the cycle after the causing edge.
REQ-023 SHALL set OVF on a rejected write (W_EN=1 not accepted) and hold it until CLR or reset.
REQ-024 SHALL set UNF on a rejected read (R_EN=1 while EMPTY=1) and hold it until CLR or reset.
REQ-025 SHALL, on CLR=1, zero both pointers, COUNT, OVF, UNF and R_VALID at the next edge; W_EN and R_EN SHALL be ignored in that cycle; R_DATA and storage contents SHALL be retained.
REQ-026 SHALL implement every control/status register (pointers, COUNT, flags, R_VALID) as an enabled flop with asynchronous active-low reset, and CLR as a synchronous clear, so that each register maps to a single SLE.
REQ-027 SHALL implement storage as a synchronous-write, registered-read array with no reset, so that it is inferable as uSRAM/LSRAM.
REQ-028 SHALL produce no combinational path from W_EN/R_EN to any output.

Reset
REQ-029 SHALL, while ALn=0, force COUNT=0, EMPTY=1, FULL=0, AFULL=0, R_VALID=0, OVF=0, UNF=0, both pointers 0, and R_DATA=0, independent of CLK.
REQ-030 SHALL, when ALn asserts mid-operation, discard all in-flight reads and writes; storage contents are undefined afterwards.
REQ-031 SHALL resume accepting requests on the first rising CLK edge after ALn deasserts.

Verification
REQ-032 Reset then idle -> EMPTY=1, COUNT=0, R_VALID=0, R_DATA=0, OVF=UNF=0.
REQ-033 Write 0x001..0x040 (64 words, DEPTH=64) -> AFULL at COUNT=60, FULL after 64th write; 65th write -> OVF=1, COUNT stays 64.
REQ-034 Read 64 words from full -> R_DATA sequence 0x001..0x040, each exactly one cycle after its R_EN; EMPTY after last read; one extra R_EN -> UNF=1, R_VALID=0.
REQ-035 FULL with simultaneous W_EN and R_EN -> both accepted, COUNT stays 64, OVF stays 0; EMPTY with both -> write only accepted, COUNT=1, UNF=1.
REQ-036 Pointer wrap: 100 interleaved write/read pairs with data = index -> every word read back in order, COUNT never exceeds 1.
REQ-037 ALn pulsed low mid-burst (COUNT=10), and CLR=1 applied with OVF=1 -> both give COUNT=0, EMPTY=1, OVF=0, with the reset taking effect without a CLK edge.

Source files
------------

// File: rtl/microchip_sync_fifo.sv
// Single-clock FIFO with registered read data, almost-full flag and sticky error flags.
// Read latency 1; no backpressure: rejected writes set OVF and rejected reads set UNF.
module microchip_sync_fifo #(
    parameter int WIDTH       = 12,
    parameter int DEPTH       = 64,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                     CLK,
    input  logic                     ALn,
    input  logic                     CLR,
    input  logic                     W_EN,
    input  logic [WIDTH-1:0]         W_DATA,
    input  logic                     R_EN,
    output logic [WIDTH-1:0]         R_DATA,
    output logic                     R_VALID,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     AFULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF,
    output logic                     UNF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rd_acc;
    logic             wr_acc;
    logic             wr_rej;
    logic             rd_rej;

    // Flags come only from the count register, so no request input reaches an output.
    assign EMPTY = (count == '0);
    assign FULL  = (count == CW'(DEPTH));
    assign AFULL = (count >= CW'(AFULL_LEVEL));
    assign COUNT = count;

    // A read frees a slot in the same cycle, so a full FIFO may still accept a write.
    assign rd_acc = !CLR && R_EN && !EMPTY;
    assign wr_acc = !CLR && W_EN && (!FULL || rd_acc);
    assign wr_rej = !CLR && W_EN && !wr_acc;
    assign rd_rej = !CLR && R_EN && EMPTY;

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= W_DATA;
        end
    end

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            R_DATA <= '0;
        end else if (rd_acc) begin
            R_DATA <= mem[rd_ptr];
        end
    end

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            R_VALID <= 1'b0;
        end else begin
            R_VALID <= rd_acc;
        end
    end

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            wr_ptr <= '0;
        end else if (CLR) begin
            wr_ptr <= '0;
        end else if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            rd_ptr <= '0;
        end else if (CLR) begin
            rd_ptr <= '0;
        end else if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            count <= '0;
        end else if (CLR) begin
            count <= '0;
        end else if (wr_acc != rd_acc) begin
            count <= wr_acc ? count + CW'(1) : count - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            OVF <= 1'b0;
        end else if (CLR) begin
            OVF <= 1'b0;
        end else if (wr_rej) begin
            OVF <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            UNF <= 1'b0;
        end else if (CLR) begin
            UNF <= 1'b0;
        end else if (rd_rej) begin
            UNF <= 1'b1;
        end
    end

endmodule
